// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared fill-state encoding and default image geometry
package img_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int DW_DEF    = 24;

    // Which line of the frame the current pixel belongs to, from the
    // point of view of how many complete lines sit in the line buffers.
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } fill_state_t;

    // Address width for a buffer or counter of n entries (never zero).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_3row_if.sv
// rtl/matrix_3row_if.sv - pixel stream in / three-row column out bundle
interface matrix_3row_if #(
    parameter int DW = img_pkg::DW_DEF
);
    logic          in_vld;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic [DW-1:0] row1_data;
    logic [DW-1:0] row2_data;
    logic [DW-1:0] row3_data;
    logic          out_vld;

    modport master (
        output in_vld, in_sof, in_data,
        input  row1_data, row2_data, row3_data, out_vld
    );

    modport slave (
        input  in_vld, in_sof, in_data,
        output row1_data, row2_data, row3_data, out_vld
    );
endinterface

// File: rtl/matrix_3row_line_buf.sv
// rtl/matrix_3row_line_buf.sv - one-line pixel store, async read, sync write
module line_buf
    import img_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF,
    localparam int AW   = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    // No reset on the array so it maps onto plain RAM.
    logic [DW-1:0] r_mem [DEPTH];

    // Write the new pixel at the same address that is being read this cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/matrix_3row.sv
// rtl/matrix_3row.sv - 3-line column window builder; MATRIX_EDGE_REPLICATE_EN enables edge replication
module matrix_3row
    import img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    matrix_3row_if.slave  bus
);
    localparam int CW = idx_w(IMG_W);
    localparam int RW = idx_w(IMG_H);

    fill_state_t   r_state;
    fill_state_t   w_state;
    fill_state_t   w_state_nxt;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row;
    logic [RW-1:0] w_row_nxt;
    logic          w_sof;
    logic          w_col_wrap;
    logic          w_row_wrap;
    logic [DW-1:0] w_a_rd;
    logic [DW-1:0] w_b_rd;
    logic [DW-1:0] w_r1;
    logic [DW-1:0] w_r2;
    logic [DW-1:0] w_r3;
    logic          w_vld;
    logic [DW-1:0] r_row1;
    logic [DW-1:0] r_row2;
    logic [DW-1:0] r_row3;
    logic          r_out_vld;

    // A start-of-frame pixel is position (0,0) in FILL0 whatever the counters say.
    assign w_sof      = bus.in_vld & bus.in_sof;
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_state    = w_sof ? FILL0 : r_state;
    assign w_col_wrap = (w_col == CW'(IMG_W - 1));
    assign w_row_wrap = w_col_wrap && (w_row == RW'(IMG_H - 1));

    // lineA holds the previous line; lineB receives what lineA drops out.
    line_buf #(.DEPTH(IMG_W), .DW(DW)) u_line_a (
        .clk     (clk),
        .i_we    (bus.in_vld),
        .i_addr  (w_col),
        .i_wdata (bus.in_data),
        .o_rdata (w_a_rd)
    );

    line_buf #(.DEPTH(IMG_W), .DW(DW)) u_line_b (
        .clk     (clk),
        .i_we    (bus.in_vld),
        .i_addr  (w_col),
        .i_wdata (w_a_rd),
        .o_rdata (w_b_rd)
    );

    // Next position/state and the window column for the pixel being accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_r3        = bus.in_data;
        w_r2        = w_a_rd;
        w_r1        = w_b_rd;
        w_vld       = (w_state == RUN);

        if (bus.in_vld) begin
            w_col_nxt = w_col_wrap ? '0 : w_col + CW'(1);
            if (w_row_wrap) begin
                w_row_nxt = '0;
            end else if (w_col_wrap) begin
                w_row_nxt = w_row + RW'(1);
            end else begin
                w_row_nxt = w_row;
            end

            w_state_nxt = w_state;
            case (w_state)
                FILL0:   if (w_col_wrap) w_state_nxt = FILL1;
                FILL1:   if (w_col_wrap) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = FILL0;
            endcase
            if (w_row_wrap) begin
                w_state_nxt = FILL0;
            end
        end

`ifdef MATRIX_EDGE_REPLICATE_EN
        // Missing lines above the frame top are filled with the nearest real line.
        w_vld = 1'b1;
        case (w_state)
            FILL0: begin
                w_r1 = bus.in_data;
                w_r2 = bus.in_data;
            end
            FILL1: begin
                w_r1 = w_a_rd;
                w_r2 = w_a_rd;
            end
            default: begin
                w_r1 = w_b_rd;
                w_r2 = w_a_rd;
            end
        endcase
`endif
    end

    // Position counters and fill state advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Window outputs update one cycle after each accepted pixel and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row1    <= '0;
            r_row2    <= '0;
            r_row3    <= '0;
            r_out_vld <= 1'b0;
        end else if (bus.in_vld) begin
            r_row1    <= w_r1;
            r_row2    <= w_r2;
            r_row3    <= w_r3;
            r_out_vld <= w_vld;
        end else begin
            r_out_vld <= 1'b0;
        end
    end

    assign bus.row1_data = r_row1;
    assign bus.row2_data = r_row2;
    assign bus.row3_data = r_row3;
    assign bus.out_vld   = r_out_vld;
endmodule

// File: tb/tb_matrix_3row.sv
// tb/tb_matrix_3row.sv - randomized and directed bench for matrix_3row against a frame-history model
module tb_matrix_3row;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_3row_if #(.DW(DW)) bus ();

    matrix_3row #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: every pixel since the last sof, indexed by arrival order.
    logic [DW-1:0] hist [$];
    int            n = -1;

    logic          o_vld;
    logic [DW-1:0] o_r1, o_r2, o_r3;
    logic          e_vld;
    logic [DW-1:0] e_r1, e_r2, e_r3;

    // Golden sequence of valid triples from the fill test, reused by the bubble test.
    logic [3*DW-1:0] fill_seq [$];

    function automatic logic [DW-1:0] pv(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    task automatic model(input bit sof, input logic [DW-1:0] d);
        int row;
        logic [DW-1:0] a, b;
        if (sof) begin
            hist.delete();
            n = 0;
        end else if (n >= 0) begin
            n++;
        end
        e_vld = 1'b0; e_r1 = '0; e_r2 = '0; e_r3 = d;
        if (n >= 0) begin
            row = (n / W) % H;
            a = (n >= W)     ? hist[n - W]     : '0;
            b = (n >= 2 * W) ? hist[n - 2 * W] : '0;
            hist.push_back(d);
            e_vld = (row >= 2);
            e_r2 = a;
            e_r1 = b;
`ifdef MATRIX_EDGE_REPLICATE_EN
            e_vld = 1'b1;
            if (row == 0) begin
                e_r1 = d; e_r2 = d;
            end else if (row == 1) begin
                e_r1 = a; e_r2 = a;
            end
`endif
        end
    endtask

    // One clock: present inputs, let the edge take them, sample 1 time unit later.
    task automatic cycle(input bit vld, input bit sof, input logic [DW-1:0] d);
        bus.in_vld  = vld;
        bus.in_sof  = sof;
        bus.in_data = d;
        @(posedge clk);
        #1;
        o_vld = bus.out_vld;
        o_r1  = bus.row1_data;
        o_r2  = bus.row2_data;
        o_r3  = bus.row3_data;
        bus.in_vld = 1'b0;
        bus.in_sof = 1'b0;
    endtask

    task automatic pix(input bit sof, input logic [DW-1:0] d);
        model(sof, d);
        cycle(1'b1, sof, d);
    endtask

    task automatic test_reset;
        bus.in_vld = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_vld, bus.row1_data, bus.row2_data, bus.row3_data} !== {1'b0, 72'h0}) begin
            errors++;
            $display("FAIL reset_state: got vld=%0b r=%h/%h/%h, expected 0 and zeros",
                     bus.out_vld, bus.row1_data, bus.row2_data, bus.row3_data);
        end
        rst_n = 1'b1;
        // Partial frame, then asynchronous reset between edges.
        for (int i = 0; i < 10; i++) pix(i == 0, pv(i / W, i % W));
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_vld, bus.row1_data, bus.row2_data, bus.row3_data} !== {1'b0, 72'h0}) begin
            errors++;
            $display("FAIL reset_async: got vld=%0b r=%h/%h/%h, expected 0 and zeros",
                     bus.out_vld, bus.row1_data, bus.row2_data, bus.row3_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = -1;
        hist.delete();
        // First pixel is taken on the first edge after release.
        for (int i = 0; i < W * H; i++) begin
            pix(i == 0, pv(i / W, i % W));
            checks++;
            if (o_vld !== e_vld) begin
                errors++;
                $display("FAIL reset_frame_vld px%0d: got %0b, expected %0b", i, o_vld, e_vld);
            end
            if (e_vld) begin
                checks++;
                if ({o_r1, o_r2, o_r3} !== {e_r1, e_r2, e_r3}) begin
                    errors++;
                    $display("FAIL reset_frame_data px%0d: got %h/%h/%h, expected %h/%h/%h",
                             i, o_r1, o_r2, o_r3, e_r1, e_r2, e_r3);
                end
            end
        end
    endtask

    task automatic test_fill;
        int cnt = 0;
        int first = -1;
        logic [3*DW-1:0] first_t = '0;
        fill_seq.delete();
        for (int i = 0; i < W * H; i++) begin
            pix(i == 0, pv(i / W, i % W));
            checks++;
            if (o_vld !== e_vld) begin
                errors++;
                $display("FAIL fill_vld px%0d: got %0b, expected %0b", i, o_vld, e_vld);
            end
            if (e_vld) begin
                checks++;
                if ({o_r1, o_r2, o_r3} !== {e_r1, e_r2, e_r3}) begin
                    errors++;
                    $display("FAIL fill_data px%0d: got %h/%h/%h, expected %h/%h/%h",
                             i, o_r1, o_r2, o_r3, e_r1, e_r2, e_r3);
                end
            end
            if (o_vld) begin
                cnt++;
                fill_seq.push_back({o_r1, o_r2, o_r3});
                if (first < 0) begin
                    first = i;
                    first_t = {o_r1, o_r2, o_r3};
                end
            end
        end
`ifndef MATRIX_EDGE_REPLICATE_EN
        checks++;
        if (cnt != 8) begin
            errors++;
            $display("FAIL fill_count: got %0d, expected 8", cnt);
        end
        checks++;
        if (first != 2 * W || first_t !== {pv(0, 0), pv(1, 0), pv(2, 0)}) begin
            errors++;
            $display("FAIL fill_first: got px%0d %h, expected px8 %h",
                     first, first_t, {pv(0, 0), pv(1, 0), pv(2, 0)});
        end
`else
        checks++;
        if (cnt != W * H) begin
            errors++;
            $display("FAIL fill_count: got %0d, expected %0d", cnt, W * H);
        end
`endif
    endtask

    task automatic test_bubble;
        int k = 0;
        int vi = 0;
        logic [3*DW-1:0] held;
        for (int i = 0; i < W * H; i++) begin
            // Gap cycles from the repeating 1,0,0,1 valid pattern.
            while (k % 4 == 1 || k % 4 == 2) begin
                held = {o_r1, o_r2, o_r3};
                cycle(1'b0, 1'b0, DW'($urandom));
                checks++;
                if (o_vld !== 1'b0 || {o_r1, o_r2, o_r3} !== held) begin
                    errors++;
                    $display("FAIL bubble_hold cyc%0d: got vld=%0b %h, expected vld=0 %h",
                             k, o_vld, {o_r1, o_r2, o_r3}, held);
                end
                k++;
            end
            pix(i == 0, pv(i / W, i % W));
            k++;
            checks++;
            if (o_vld !== e_vld) begin
                errors++;
                $display("FAIL bubble_vld px%0d: got %0b, expected %0b", i, o_vld, e_vld);
            end
            if (o_vld) begin
                checks++;
                if (vi >= fill_seq.size() || {o_r1, o_r2, o_r3} !== fill_seq[vi]) begin
                    errors++;
                    $display("FAIL bubble_seq px%0d: got %h, expected entry %0d of fill sequence",
                             i, {o_r1, o_r2, o_r3}, vi);
                end
                vi++;
            end
        end
        checks++;
        if (vi != fill_seq.size()) begin
            errors++;
            $display("FAIL bubble_count: got %0d, expected %0d", vi, fill_seq.size());
        end
    endtask

    task automatic test_wrap;
        int cnt [2];
        logic [3*DW-1:0] first_t [2];
        cnt[0] = 0; cnt[1] = 0;
        first_t[0] = '0; first_t[1] = '0;
        for (int i = 0; i < 2 * W * H; i++) begin
            pix(i == 0, pv((i / W) % H, i % W));
            checks++;
            if (o_vld !== e_vld || (e_vld && {o_r1, o_r2, o_r3} !== {e_r1, e_r2, e_r3})) begin
                errors++;
                $display("FAIL wrap_px%0d: got vld=%0b %h/%h/%h, expected vld=%0b %h/%h/%h",
                         i, o_vld, o_r1, o_r2, o_r3, e_vld, e_r1, e_r2, e_r3);
            end
            if (o_vld) begin
                if (cnt[i / (W * H)] == 0) first_t[i / (W * H)] = {o_r1, o_r2, o_r3};
                cnt[i / (W * H)]++;
            end
        end
        checks++;
        if (cnt[1] != cnt[0] || first_t[1] !== first_t[0]) begin
            errors++;
            $display("FAIL wrap_frame2: got %0d valids first %h, expected %0d first %h",
                     cnt[1], first_t[1], cnt[0], first_t[0]);
        end
`ifndef MATRIX_EDGE_REPLICATE_EN
        checks++;
        if (cnt[1] != 8 || first_t[1] !== {pv(0, 0), pv(1, 0), pv(2, 0)}) begin
            errors++;
            $display("FAIL wrap_golden: got %0d first %h, expected 8 first %h",
                     cnt[1], first_t[1], {pv(0, 0), pv(1, 0), pv(2, 0)});
        end
`endif
    endtask

`ifdef MATRIX_EDGE_REPLICATE_EN
    task automatic test_edge;
        int cnt = 0;
        for (int i = 0; i < W * H; i++) begin
            pix(i == 0, pv(i / W, i % W));
            if (o_vld) cnt++;
            checks++;
            if ({o_r1, o_r2, o_r3} !== {e_r1, e_r2, e_r3}) begin
                errors++;
                $display("FAIL edge_data px%0d: got %h/%h/%h, expected %h/%h/%h",
                         i, o_r1, o_r2, o_r3, e_r1, e_r2, e_r3);
            end
            if (i == 1) begin
                checks++;
                if ({o_r1, o_r2, o_r3} !== {DW'(1), DW'(1), DW'(1)}) begin
                    errors++;
                    $display("FAIL edge_p01: got %h/%h/%h, expected 01/01/01", o_r1, o_r2, o_r3);
                end
            end
            if (i == W + 2) begin
                checks++;
                if ({o_r1, o_r2, o_r3} !== {DW'(2), DW'(2), DW'('h12)}) begin
                    errors++;
                    $display("FAIL edge_p12: got %h/%h/%h, expected 02/02/12", o_r1, o_r2, o_r3);
                end
            end
        end
        checks++;
        if (cnt != W * H) begin
            errors++;
            $display("FAIL edge_count: got %0d, expected %0d", cnt, W * H);
        end
    endtask
`endif

    task automatic test_resync;
        int cnt = 0;
        int v = 'h22;
        for (int i = 0; i < 2 * W + 1; i++) pix(i == 0, pv(i / W, i % W));
        // sof lands on the pixel that would have been (row 2, col 1).
        for (int i = 0; i < 9; i++) begin
            if (i == 0) pix(1'b1, pv(2, 1));
            else begin
                pix(1'b0, DW'(v));
                v++;
            end
            checks++;
            if (o_vld !== e_vld || (e_vld && {o_r1, o_r2, o_r3} !== {e_r1, e_r2, e_r3})) begin
                errors++;
                $display("FAIL resync_px%0d: got vld=%0b %h/%h/%h, expected vld=%0b %h/%h/%h",
                         i, o_vld, o_r1, o_r2, o_r3, e_vld, e_r1, e_r2, e_r3);
            end
            if (i < 8 && o_vld) cnt++;
        end
`ifndef MATRIX_EDGE_REPLICATE_EN
        checks++;
        if (cnt != 0 || o_vld !== 1'b1) begin
            errors++;
            $display("FAIL resync_silent: got %0d valids then vld=%0b, expected 0 then 1", cnt, o_vld);
        end
`endif
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1) begin
                pix(i == 0 || $urandom_range(0, 39) == 0, DW'($urandom));
                checks++;
                if (o_vld !== e_vld || o_r3 !== e_r3 ||
                    (e_vld && {o_r1, o_r2} !== {e_r1, e_r2})) begin
                    errors++;
                    $display("FAIL random_cyc%0d: got vld=%0b %h/%h/%h, expected vld=%0b %h/%h/%h",
                             i, o_vld, o_r1, o_r2, o_r3, e_vld, e_r1, e_r2, e_r3);
                end
            end else begin
                cycle(1'b0, 1'b0, DW'($urandom));
                checks++;
                if (o_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL random_idle_cyc%0d: got vld=%0b, expected 0", i, o_vld);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_bubble();
        test_wrap();
`ifdef MATRIX_EDGE_REPLICATE_EN
        test_edge();
`endif
        test_resync();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_3row.md
MATRIX_3ROW -- requirements
Module: matrix_3row

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have parameter DW, default 24, pixel width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_vld  input  1  input pixel valid, one pixel per asserted cycle.
REQ-007 SHALL have port in_sof  input  1  start of frame, qualified by in_vld, marks pixel (row 0, col 0).
REQ-008 SHALL have port in_data  input  DW  input pixel.
REQ-009 SHALL have port row1_data  output  DW  pixel two lines above, same column.
REQ-010 SHALL have port row2_data  output  DW  pixel one line above, same column.
REQ-011 SHALL have port row3_data  output  DW  current-line pixel.
REQ-012 SHALL have port out_vld  output  1  row1..row3 valid, column-aligned, ready for the three-input sorter.

Function
REQ-013 SHALL keep col counter 0..IMG_W-1, advanced only on in_vld, wrapping to 0 after IMG_W-1.
REQ-014 SHALL keep row counter 0..IMG_H-1, incremented on col wrap, wrapping to 0 after IMG_H-1.
REQ-015 SHALL, on in_vld with in_sof, treat that pixel as col 0 / row 0 regardless of counter state, and enter state FILL0.
REQ-016 SHALL use a state machine with states FILL0 (row 0), FILL1 (row 1), RUN (row >= 2); FILL0->FILL1 and FILL1->RUN on col wrap; RUN->FILL0 on row wrap or in_sof.
REQ-017 SHALL, on each in_vld cycle: row3_data <= in_data, row2_data <= lineA[col], row1_data <= lineB[col], lineA[col] <= in_data, lineB[col] <= lineA[col] (read-before-write).
REQ-018 SHALL produce outputs exactly 1 cycle after the accepted input pixel; out_vld is a 1-cycle pulse per accepted pixel.
REQ-019 SHALL assert out_vld only for pixels accepted in RUN (see REQ-027 for the override).
REQ-020 SHALL hold row*_data, counters, state, and line-buffer contents unchanged when in_vld=0; out_vld=0 on those cycles.
REQ-021 SHALL tolerate arbitrary in_vld gaps, including mid-line, with no effect on alignment.

Reset
REQ-022 SHALL, while rst_n=0, force row1_data, row2_data, row3_data = 0, out_vld = 0, col = 0, row = 0, state = FILL0.
REQ-023 SHALL NOT reset line-buffer memory contents; reset mid-frame discards alignment, and the next in_sof restarts cleanly.
REQ-024 SHALL accept a pixel on the first clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro MATRIX_EDGE_REPLICATE_EN.
REQ-026 SHALL, without the macro, behave per REQ-019: the first two lines of each frame produce no out_vld.
REQ-027 SHALL, with the macro defined, assert out_vld in all states, with the following edge replication:
- FILL0: row1 = row2 = row3 = in_data.
- FILL1: row1 = row2 = lineA[col].

Structure
REQ-028 SHALL place the state encoding typedef (FILL0/FILL1/RUN) and default IMG_W/IMG_H/DW constants in shared package img_pkg.
REQ-029 SHALL implement each line buffer as sub-module line_buf: depth IMG_W, width DW, with combinational read and synchronous write at the same address; the block instantiates it twice (lineA, lineB).
REQ-030 SHALL have lineA/lineB map to inferred RAM; no reset on the memory array.

Verification (IMG_W=4, IMG_H=4, pixel value = row*16+col)
REQ-031 Reset check: assert rst_n=0 mid-stream -> all outputs 0 and out_vld=0 within the same cycle; the next in_sof frame matches the golden output exactly.
REQ-032 Fill check: feed a full 4x4 frame continuously, macro off -> out_vld count = 8; the first valid output (pixel row 2, col 0) is row1=0x00, row2=0x10, row3=0x20, one cycle after input.
REQ-033 Bubble check: same frame with in_vld toggling 1,0,0,1 -> identical output sequence to REQ-032, with each output exactly 1 cycle after its input.
REQ-034 Wrap check: two back-to-back frames without re-asserting in_sof -> frame 2 behaves identically to frame 1 (8 valids, first triple 0x00/0x10/0x20).
REQ-035 Edge-replicate check: macro on, same frame -> 16 valids; pixel (0,1) gives 0x01/0x01/0x01; pixel (1,2) gives 0x02/0x02/0x12.
REQ-036 Resync check: assert in_sof at pixel (2,1) -> state FILL0; the next 8 pixels produce no out_vld with the macro off.
